// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory responder.
package cpu_mem_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] DEF_DONE_ADDR = 32'h0000_0010;
  localparam logic [WORD_W-1:0] DEF_CYC_ADDR  = 32'h0000_0014;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_mem_ram.sv
// Byte-strobed single-port RAM; combinational read, write on the clock edge.
// The responder holds the address stable, so the read is valid throughout RESP.
module cpu_mem_ram
  import cpu_mem_pkg::*;
#(
  parameter int unsigned WORDS = 4096,
  parameter int unsigned AW    = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        wstrb,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory/MMIO responder for a valid/ready CPU bus: response WAIT_CYCLES+1 cycles after acceptance.
// The CPU holds mem_valid until mem_ready; dropping it while waiting aborts the access and flags err.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned       MEM_WORDS   = 4096,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [WORD_W-1:0] DONE_ADDR   = DEF_DONE_ADDR,
  parameter logic [WORD_W-1:0] CYC_ADDR    = DEF_CYC_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              done,
  output logic [WORD_W-1:0] done_code,
  output logic              err
);

  localparam int unsigned AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [29:0]       word_q;
  logic [WORD_W-1:0] wdata_q, cyc_q, rdata_q, code_q;
  logic [3:0]        wstrb_q;
  logic              done_q, err_q, abort;
  logic              hit_done, hit_cyc, in_ram, hit_ram, is_wr, ram_we;
  logic [WORD_W-1:0] ram_rdata, resp_rdata;
  logic              unused_addr_lsb;

  // Byte offset is irrelevant: every target is a full 32-bit word.
  assign unused_addr_lsb = ^mem_addr[1:0];

  assign hit_done = (word_q == DONE_ADDR[31:2]);
  assign hit_cyc  = !hit_done && (word_q == CYC_ADDR[31:2]);
  assign in_ram   = ({2'b00, word_q} < 32'(MEM_WORDS));
  assign hit_ram  = in_ram && !hit_done && !hit_cyc;
  assign is_wr    = |wstrb_q;
  assign ram_we   = (state_q == ST_RESP) && is_wr && hit_ram && !rst;

  cpu_mem_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .wstrb (wstrb_q),
    .addr  (word_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          wcnt_d  = WAIT_LD;
          state_d = (WAIT_LD != 4'd0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!mem_valid) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    resp_rdata = '0;
    if (hit_done)     resp_rdata = code_q;
    else if (hit_cyc) resp_rdata = cyc_q;
    else if (in_ram)  resp_rdata = ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cyc_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      code_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cyc_q   <= cyc_q + 32'd1;
      if (state_q == ST_IDLE && mem_valid) begin
        word_q  <= mem_addr[31:2];
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
      if (state_q == ST_RESP) begin
        rdata_q <= resp_rdata;
        if (is_wr && hit_done) begin
          done_q <= 1'b1;
          if (!done_q) code_q <= wdata_q;
        end
        if (!hit_done && !hit_cyc && !in_ram) err_q <= 1'b1;
      end
      if (abort) err_q <= 1'b1;
    end
  end

  // Read data is live during RESP and frozen afterwards.
  assign mem_ready = (state_q == ST_RESP);
  assign mem_rdata = (state_q == ST_RESP) ? resp_rdata : rdata_q;
  assign done      = done_q;
  assign done_code = code_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: three instances with WAIT_CYCLES 1, 0 and 3.
module tb_cpu_mem_responder;

  localparam int NDUT = 3;
  localparam int WCS [NDUT] = '{1, 0, 3};
  localparam logic [31:0] DONE_A = 32'h0000_0010;
  localparam logic [31:0] CYC_A  = 32'h0000_0014;
  localparam logic [31:0] OOR_A  = 32'h0000_4000;

  logic                  clk = 1'b0;
  logic [NDUT-1:0]       rst;
  logic [NDUT-1:0]       valid;
  logic [NDUT-1:0][31:0] addr;
  logic [NDUT-1:0][31:0] wdata;
  logic [NDUT-1:0][3:0]  wstrb;
  logic [NDUT-1:0]       ready;
  logic [NDUT-1:0][31:0] rdata;
  logic [NDUT-1:0]       done;
  logic [NDUT-1:0][31:0] code;
  logic [NDUT-1:0]       err;

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    cpu_mem_responder #(
      .MEM_WORDS   (4096),
      .WAIT_CYCLES (WCS[g]),
      .DONE_ADDR   (DONE_A),
      .CYC_ADDR    (CYC_A)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .mem_valid (valid[g]),
      .mem_addr  (addr[g]),
      .mem_wdata (wdata[g]),
      .mem_wstrb (wstrb[g]),
      .mem_ready (ready[g]),
      .mem_rdata (rdata[g]),
      .done      (done[g]),
      .done_code (code[g]),
      .err       (err[g])
    );
  end

  task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] exp_rd, input bit chk);
    exp_t e;
    int   edges;
    bit   got;
    e.rdata = exp_rd;
    e.chk   = chk;
    e.lat   = WCS[d] + 1;
    sbq.push_back(e);
    @(negedge clk);
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = st;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (ready[d] === 1'b1) got = 1'b1;
    end
    valid[d] = 1'b0; wstrb[d] = 4'b0;
    e = sbq.pop_front();
    n_run++;
    if (!got || edges != e.lat) begin
      n_fail++;
      $display("FAIL latency dut%0d addr %h: got %0d edges (ready seen %0b), want %0d", d, a, edges, got, e.lat);
    end
    if (e.chk) begin
      n_run++;
      if (rdata[d] !== e.rdata) begin
        n_fail++;
        $display("FAIL rdata dut%0d addr %h: got %h want %h", d, a, rdata[d], e.rdata);
      end
    end
    @(posedge clk); #1;
    n_run++;
    if (ready[d] !== 1'b0 || (e.chk && rdata[d] !== e.rdata)) begin
      n_fail++;
      $display("FAIL pulse_hold dut%0d addr %h: ready %b rdata %h want 0/%h", d, a, ready[d], rdata[d], e.rdata);
    end
  endtask

  task automatic check_idle_outs(input int d, input string tag);
    n_run++;
    if (ready[d] !== 1'b0 || rdata[d] !== 32'h0 || done[d] !== 1'b0 ||
        code[d] !== 32'h0 || err[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s dut%0d: ready %b rdata %h done %b code %h err %b want all zero",
               tag, d, ready[d], rdata[d], done[d], code[d], err[d]);
    end
  endtask

  task automatic test_reset();
    rst = '1; valid = '0; addr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) check_idle_outs(d, "reset_state");
    rst = '0;
  endtask

  task automatic test_cycle_counter();
    @(negedge clk); rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); rst[0] = 1'b0;
    repeat (100) @(posedge clk);
    access(0, CYC_A, 32'h0, 4'b0000, 32'(100 + 1 + WCS[0]), 1'b1);
  endtask

  task automatic test_write_read();
    access(0, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
    access(0, 32'h100, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b1);
    access(0, 32'h100, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0);
    access(0, 32'h101, 32'h0, 4'b0000, 32'hDEAD_BEAA, 1'b1);
    access(0, 32'h104, 32'h0102_0304, 4'b1111, 32'h0, 1'b0);
    access(0, 32'h100, 32'h1234_5678, 4'b0110, 32'h0, 1'b0);
    access(0, 32'h100, 32'h0, 4'b0000, 32'hDE34_56AA, 1'b1);
    access(0, 32'h104, 32'h0, 4'b0000, 32'h0102_0304, 1'b1);
  endtask

  task automatic test_done();
    n_run++;
    if (done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pre: got %b want 0", done[0]);
    end
    access(0, DONE_A, 32'h0000_0001, 4'b1111, 32'h0, 1'b0);
    n_run++;
    if (done[0] !== 1'b1 || code[0] !== 32'h1) begin
      n_fail++;
      $display("FAIL done_first: done %b code %h want 1/00000001", done[0], code[0]);
    end
    access(0, DONE_A, 32'h0000_0002, 4'b0001, 32'h0, 1'b0);
    n_run++;
    if (done[0] !== 1'b1 || code[0] !== 32'h1) begin
      n_fail++;
      $display("FAIL done_sticky: done %b code %h want 1/00000001", done[0], code[0]);
    end
    access(0, DONE_A, 32'h0, 4'b0000, 32'h0000_0001, 1'b1);
    access(0, CYC_A, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b0);
    n_run++;
    if (err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL cyc_write_err: got %b want 0", err[0]);
    end
  endtask

  task automatic test_out_of_range();
    access(0, OOR_A, 32'h0, 4'b0000, 32'h0, 1'b1);
    n_run++;
    if (err[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_err dut0: got %b want 1", err[0]);
    end
    access(1, 32'h100, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0);
    access(1, 32'h100, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b1);
    n_run++;
    if (err[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_oor_err dut1: got %b want 0", err[1]);
    end
    access(1, OOR_A + 32'h4, 32'h5555_5555, 4'b1111, 32'h0, 1'b0);
    access(1, OOR_A, 32'h0, 4'b0000, 32'h0, 1'b1);
    n_run++;
    if (err[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_err dut1: got %b want 1", err[1]);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    access(2, 32'h200, 32'h1111_1111, 4'b1111, 32'h0, 1'b0);
    access(2, DONE_A, 32'h0000_0005, 4'b1111, 32'h0, 1'b0);
    access(2, OOR_A, 32'h0, 4'b0000, 32'h0, 1'b1);
    @(negedge clk);
    valid[2] = 1'b1; addr[2] = 32'h200; wdata[2] = 32'h2222_2222; wstrb[2] = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b1; valid[2] = 1'b0; wstrb[2] = 4'b0;
    @(posedge clk); #1;
    check_idle_outs(2, "mid_reset");
    @(negedge clk); rst[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready[2] !== 1'b0) seen = 1'b1;
    end
    n_run++;
    if (seen) begin
      n_fail++;
      $display("FAIL mid_reset_ready: ready seen 1 want 0");
    end
    access(2, 32'h200, 32'h0, 4'b0000, 32'h1111_1111, 1'b1);
  endtask

  task automatic test_abort();
    bit seen;
    n_run++;
    if (err[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pre_err: got %b want 0", err[2]);
    end
    @(negedge clk);
    valid[2] = 1'b1; addr[2] = 32'h200; wdata[2] = 32'h3333_3333; wstrb[2] = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    valid[2] = 1'b0; wstrb[2] = 4'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready[2] !== 1'b0) seen = 1'b1;
    end
    n_run++;
    if (seen || err[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort: ready seen %b err %b want 0/1", seen, err[2]);
    end
    access(2, 32'h200, 32'h0, 4'b0000, 32'h1111_1111, 1'b1);
  endtask

  initial begin
    test_reset();
    test_cycle_counter();
    test_write_read();
    test_done();
    test_out_of_range();
    test_reset_mid();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 4096: RAM depth in 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 1: wait states inserted before each mem_ready (0..15).
REQ-003 Parameter DONE_ADDR, default 32'h0000_0010: MMIO done/result register.
REQ-004 Parameter CYC_ADDR, default 32'h0000_0014: MMIO read-only cycle counter.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 mem_valid  in  1  CPU request valid, held until mem_ready seen.
REQ-008 mem_addr  in  32  byte address; bits [1:0] ignored.
REQ-009 mem_wdata  in  32  write data.
REQ-010 mem_wstrb  in  4  byte write strobes; 4'b0000 = read.
REQ-011 mem_ready  out  1  one-cycle completion pulse.
REQ-012 mem_rdata  out  32  read data, valid while mem_ready=1.
REQ-013 done  out  1  sticky, set by any write to DONE_ADDR.
REQ-014 done_code  out  32  data of the first write to DONE_ADDR.
REQ-015 err  out  1  sticky: out-of-range access or protocol violation.

Function
REQ-016 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-017 IDLE and mem_valid=1 at an edge: latch addr/wdata/wstrb, load wait counter with WAIT_CYCLES; go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-018 WAIT: decrement counter each cycle; at count 1 go to RESP; total WAIT residence = WAIT_CYCLES cycles.
REQ-019 RESP: mem_ready=1 for exactly one cycle, then IDLE unconditionally; mem_ready=0 in every other state.
REQ-020 Latency: acceptance edge N, mem_ready high during cycle N+1+WAIT_CYCLES.
REQ-021 Writes commit at the edge ending the RESP cycle, only bytes with mem_wstrb[i]=1 (RAM byte i = wdata[8i+7:8i]).
REQ-022 Decode priority: DONE_ADDR, then CYC_ADDR, then RAM (word index addr[31:2] < MEM_WORDS), else out-of-range.
REQ-023 Read of DONE_ADDR returns done_code; read of CYC_ADDR returns cycle counter value sampled at RESP.
REQ-024 Write to DONE_ADDR with any nonzero strobe: done=1; done_code=full wdata only if done was 0; later writes ignored.
REQ-025 Write to CYC_ADDR ignored, no err.
REQ-026 Out-of-range: read returns 32'h0, write dropped, mem_ready still issued, err=1.
REQ-027 Cycle counter: 32-bit, +1 every cycle after reset, wraps at 2^32-1 to 0.
REQ-028 mem_valid falling in WAIT: abort to IDLE, no write, no mem_ready, err=1.
REQ-029 mem_rdata holds its last value outside RESP; read-during-write to same word not possible (one access in flight).

Reset
REQ-030 rst=1 at an edge: state IDLE, mem_ready=0, mem_rdata=0, done=0, done_code=0, err=0, cycle counter=0.
REQ-031 Reset in WAIT or RESP: pending write dropped, no mem_ready in the following cycle.
REQ-032 RAM contents not cleared by reset.

Structure
REQ-033 Package cpu_mem_pkg holds FSM state enum, default DONE_ADDR/CYC_ADDR constants, and word-width constant.
REQ-034 Sub-module cpu_mem_ram: single-port, byte-strobed, MEM_WORDS x 32, one write port, combinational-or-registered read matched to the RESP cycle.

Verification
REQ-035 WAIT_CYCLES=1: write 0xDEADBEEF, strb 4'b1111 to 0x100, then read 0x100 -> each mem_ready in cycle N+2; read returns 0xDEADBEEF.
REQ-036 Write 0x000000AA strb 4'b0001 over 0xDEADBEEF at 0x100 -> read returns 0xDEADBEAA.
REQ-037 Write 0x1 then 0x2 to 0x10 -> done=1 after first RESP, done_code=0x00000001 held; read of 0x10 returns 0x1.
REQ-038 Read at word index MEM_WORDS -> mem_rdata=0, mem_ready pulses, err=1; WAIT_CYCLES=0 run: mem_ready in cycle N+1.
REQ-039 WAIT_CYCLES=3, assert rst in second WAIT cycle of a write to 0x200 -> no mem_ready, 0x200 unchanged, all outputs at reset values.
REQ-040 Read 0x14 after 100 post-reset cycles -> value 100+1+WAIT_CYCLES +/- 0 per REQ-020/023 timing.
